// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: definitions shared by the multicycle MIPS control path.
//   state_t      - FSM state encoding (4-bit, legacy values kept explicit)
//   OP_*         - 6-bit primary opcodes (Instruccion[31:26])
//   ALU_*        - ALUOp codes handed to the ALU control block
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMRD    = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWR    = 4'd6,
    ST_RTYPE_EX = 4'd7,
    ST_RTYPE_WB = 4'd8,
    ST_BEQ_EX   = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
    ST_J_EX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS datapath.
// Ports:
//   clk, rst_n (async, active-low)
//   OP         - opcode from the instruction register, sampled in DECODE only
//   mem_ready  - memory access complete
//   PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg,
//   RegWrite, RegDst, ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], PCSource[1:0]
//              - datapath strobes/selects decoded from the current state
//   instr_done - registered pulse after the last state of a legal instruction
//   illegal_op - registered pulse after DECODE saw an undefined opcode
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] OP,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemToWrite,
  output logic            IRWrite,
  output logic            MemToReg,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            instr_done,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] C_RTYPE = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] C_LW    = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] C_SW    = OP_W'(OP_SW);
  localparam logic [OP_W-1:0] C_BEQ   = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] C_ADDI  = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] C_J     = OP_W'(OP_J);

  state_t state, state_nx;
  logic   is_sw;     // lw/sw choice captured in DECODE so MEMADR ignores OP
  logic   fin;       // current state completes a legal instruction
  logic   illegal;   // DECODE holds an undefined opcode

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      is_sw      <= 1'b0;
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nx;
      if (state == ST_DECODE)
        is_sw <= (OP == C_SW);
      instr_done <= fin;
      illegal_op <= illegal;
    end
  end

  always_comb begin
    state_nx    = state;
    fin         = 1'b0;
    illegal     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemToWrite  = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = ALU_ADD;
    PCSource    = '0;

    case (state)
      ST_IDLE: state_nx = ST_FETCH;

      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR and PC only latch once the fetch read has returned
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)
          state_nx = ST_DECODE;
      end

      ST_DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          C_LW, C_SW: state_nx = ST_MEMADR;
          C_RTYPE:    state_nx = ST_RTYPE_EX;
          C_BEQ:      state_nx = ST_BEQ_EX;
          C_ADDI:     state_nx = ST_ADDI_EX;
          C_J:        state_nx = ST_J_EX;
          default: begin
            state_nx = ST_FETCH;
            illegal  = 1'b1;
          end
        endcase
      end

      ST_MEMADR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = is_sw ? ST_MEMWR : ST_MEMRD;
      end

      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          state_nx = ST_MEMWB;
      end

      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        fin      = 1'b1;
        state_nx = ST_FETCH;
      end

      ST_MEMWR: begin
        MemToWrite = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) begin
          fin      = 1'b1;
          state_nx = ST_FETCH;
        end
      end

      ST_RTYPE_EX: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_FUNCT;
        state_nx = ST_RTYPE_WB;
      end

      ST_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        fin      = 1'b1;
        state_nx = ST_FETCH;
      end

      ST_BEQ_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        fin         = 1'b1;
        state_nx    = ST_FETCH;
      end

      ST_ADDI_EX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        state_nx = ST_ADDI_WB;
      end

      ST_ADDI_WB: begin
        RegWrite = 1'b1;
        fin      = 1'b1;
        state_nx = ST_FETCH;
      end

      ST_J_EX: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        fin      = 1'b1;
        state_nx = ST_FETCH;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// The reference model expands each instruction into its sequence of named
// control steps and pushes one expected control word per cycle; a monitor
// pops and compares one word per cycle against the DUT outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OP = '0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite;
  logic       MemToReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       instr_done, illegal_op;

  multicycle_control #(.OP_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemToWrite(MemToWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // PCWrite PCWriteCond IorD MemRead MemToWrite IRWrite MemToReg RegWrite
  // RegDst ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0] instr_done illegal_op
  logic [18:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite,
                MemToReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, instr_done, illegal_op};

  typedef struct {
    string       step;
    logic [18:0] w;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  logic done_pend = 1'b0;
  logic ill_pend  = 1'b0;

  // Expected control word for a named step, built from the per-step
  // strobe list; anything not named is 0.
  function automatic logic [18:0] word(input string s, input logic mr,
                                       input logic dn, input logic il);
    logic       pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, memr = 1'b0;
    logic       memw = 1'b0, irw = 1'b0, m2r = 1'b0, regw = 1'b0;
    logic       rdst = 1'b0, srca = 1'b0;
    logic [1:0] srcb = 2'b00, pcs = 2'b00;
    logic [2:0] aop = 3'b000;
    case (s)
      "FETCH":    begin memr = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      "DECODE":   srcb = 2'b11;
      "MEMADR":   begin srca = 1'b1; srcb = 2'b10; end
      "MEMRD":    begin memr = 1'b1; iord = 1'b1; end
      "MEMWB":    begin regw = 1'b1; m2r = 1'b1; end
      "MEMWR":    begin memw = 1'b1; iord = 1'b1; end
      "RTYPE_EX": begin srca = 1'b1; aop = 3'b010; end
      "RTYPE_WB": begin regw = 1'b1; rdst = 1'b1; end
      "BEQ_EX":   begin srca = 1'b1; aop = 3'b001; pcwc = 1'b1; pcs = 2'b01; end
      "ADDI_EX":  begin srca = 1'b1; srcb = 2'b10; end
      "ADDI_WB":  regw = 1'b1;
      "J_EX":     begin pcw = 1'b1; pcs = 2'b10; end
      default:    ;
    endcase
    return {pcw, pcwc, iord, memr, memw, irw, m2r, regw, rdst, srca,
            srcb, aop, pcs, dn, il};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs at the falling edge, push the expected word.
  task automatic cyc(input string s, input logic [5:0] op, input logic mr,
                     input logic rst_val);
    exp_t e;
    @(negedge clk);
    rst_n     = rst_val;
    OP        = op;
    mem_ready = mr;
    #1;
    e.step = s;
    e.w    = word(s, mr, done_pend, ill_pend);
    expq.push_back(e);
    done_pend = 1'b0;
    ill_pend  = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input bit rst_ex);
    for (int i = 0; i < fw; i++) cyc("FETCH", rop(), 1'b0, 1'b1);
    cyc("FETCH", rop(), 1'b1, 1'b1);
    cyc("DECODE", op, rb(), 1'b1);
    case (op)
      6'b100011: begin
        cyc("MEMADR", rop(), rb(), 1'b1);
        for (int i = 0; i < mw; i++) cyc("MEMRD", rop(), 1'b0, 1'b1);
        cyc("MEMRD", rop(), 1'b1, 1'b1);
        cyc("MEMWB", rop(), rb(), 1'b1);
        done_pend = 1'b1;
      end
      6'b101011: begin
        cyc("MEMADR", rop(), rb(), 1'b1);
        for (int i = 0; i < mw; i++) cyc("MEMWR", rop(), 1'b0, 1'b1);
        cyc("MEMWR", rop(), 1'b1, 1'b1);
        done_pend = 1'b1;
      end
      6'b000000: begin
        cyc("RTYPE_EX", rop(), rb(), 1'b1);
        if (rst_ex) begin
          #2;                    // past the monitor's sample of RTYPE_EX
          rst_n = 1'b0;
          #1;
          checks++;
          if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_rtype actual=%b required=%b", act, 19'b0);
          end
          done_pend = 1'b0;
          ill_pend  = 1'b0;
          cyc("IDLE", rop(), rb(), 1'b0);
          cyc("IDLE", rop(), rb(), 1'b1);
        end else begin
          cyc("RTYPE_WB", rop(), rb(), 1'b1);
          done_pend = 1'b1;
        end
      end
      6'b000100: begin
        cyc("BEQ_EX", rop(), rb(), 1'b1);
        done_pend = 1'b1;
      end
      6'b001000: begin
        cyc("ADDI_EX", rop(), rb(), 1'b1);
        cyc("ADDI_WB", rop(), rb(), 1'b1);
        done_pend = 1'b1;
      end
      6'b000010: begin
        cyc("J_EX", rop(), rb(), 1'b1);
        done_pend = 1'b1;
      end
      default: ill_pend = 1'b1;
    endcase
  endtask

  // Monitor: one comparison per cycle, sampled mid-low-phase.
  always @(negedge clk) begin
    exp_t e;
    #2;
    cycle_no++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (act !== e.w) begin
        errors++;
        $display("FAIL ctrl_%s cycle=%0d actual=%b required=%b",
                 e.step, cycle_no, act, e.w);
      end
    end
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    ops[6] = 6'b111111;

    // reset held, then released: IDLE for one cycle, then FETCH
    cyc("IDLE", rop(), rb(), 1'b0);
    cyc("IDLE", rop(), rb(), 1'b0);
    cyc("IDLE", rop(), rb(), 1'b1);

    // directed cases
    run_instr(6'b100011, 0, 0, 1'b0);   // lw, 5 cycles
    run_instr(6'b101011, 0, 3, 1'b0);   // sw, MemToWrite 4 cycles
    run_instr(6'b000100, 0, 0, 1'b0);   // beq
    run_instr(6'b111111, 0, 0, 1'b0);   // illegal
    run_instr(6'b000000, 0, 0, 1'b1);   // reset during RTYPE_EX
    run_instr(6'b000000, 2, 0, 1'b0);   // fetch waits 2 cycles
    run_instr(6'b001000, 0, 0, 1'b0);   // addi
    run_instr(6'b000010, 0, 0, 1'b0);   // j

    // randomized stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = rop();
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                (op == 6'b000000) && ($urandom_range(0, 7) == 0));
    end

    // one more cycle so the last status pulse is observed
    cyc("FETCH", rop(), 1'b0, 1'b1);
    @(negedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have the parameter OP_W, default 6, meaning the opcode width (Instruccion[31:26]).
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have the port OP, input, OP_W bits: the opcode taken from the instruction register.
REQ-005 SHALL have the port mem_ready, input, 1 bit: memory has completed the current read or write access.
REQ-006 SHALL have the 1-bit outputs PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg, RegWrite and RegDst.
REQ-007 SHALL have the outputs ALUSrcA (1 bit), ALUSrcB (2 bits), ALUOp (3 bits) and PCSource (2 bits).
REQ-008 SHALL have the status outputs instr_done (1 bit) and illegal_op (1 bit), each a one-cycle pulse.

Function
REQ-009 SHALL be a Moore FSM with the states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB and J_EX.
REQ-010 SHALL decode these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-011 SHALL always go IDLE -> FETCH on the first clock edge after reset is released.
REQ-012 SHALL stay in FETCH while mem_ready=0, and go to DECODE on the edge where mem_ready=1.
REQ-013 SHALL, in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000 (add), PCSource=00; IRWrite and PCWrite equal mem_ready.
REQ-014 SHALL, in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target precompute).
REQ-015 SHALL leave DECODE to: lw/sw -> MEMADR; R -> RTYPE_EX; beq -> BEQ_EX; addi -> ADDI_EX; j -> J_EX; any other opcode -> FETCH.
REQ-016 SHALL, in MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; go to MEMRD for lw, MEMWR for sw.
REQ-017 SHALL, in MEMRD: MemRead=1, IorD=1; stay while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-018 SHALL, in MEMWB: RegWrite=1, MemToReg=1, RegDst=0; go to FETCH.
REQ-019 SHALL, in MEMWR: MemToWrite=1, IorD=1; stay while mem_ready=0; go to FETCH when mem_ready=1.
REQ-020 SHALL, in RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=010 (funct-decoded); go to RTYPE_WB.
REQ-021 SHALL, in RTYPE_WB: RegWrite=1, RegDst=1, MemToReg=0; go to FETCH.
REQ-022 SHALL, in BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=001 (sub), PCWriteCond=1, PCSource=01; go to FETCH.
REQ-023 SHALL, in ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=000; go to ADDI_WB.
REQ-024 SHALL, in ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0; go to FETCH.
REQ-025 SHALL, in J_EX: PCWrite=1, PCSource=10; go to FETCH.
REQ-026 SHALL drive every output not listed for a state to 0 in that state.
REQ-027 SHALL pulse instr_done, registered, in the cycle after the final state of each legal instruction (MEMWB, MEMWR with mem_ready=1, RTYPE_WB, BEQ_EX, ADDI_WB, J_EX).
REQ-028 SHALL pulse illegal_op, registered, in the cycle after a DECODE state that held an undefined opcode; instr_done SHALL stay 0 for that instruction.
REQ-029 SHALL sample OP only in DECODE; OP changes in any other state SHALL have no effect.
REQ-030 SHALL, at the same edge that ends a write (MemToWrite) or write-back (RegWrite) state, already be in the next state with that strobe deasserted.
REQ-031 SHALL, given latencies with mem_ready=1 throughout, take: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-032 SHALL, while rst_n=0, force the state to IDLE and drive all outputs, including instr_done and illegal_op, to 0 immediately.
REQ-033 SHALL, on reset asserted in mid-instruction, abandon that instruction with no further write strobes; after release it SHALL restart at FETCH.

Structure
REQ-034 SHALL take the state encoding, the opcode constants and the ALUOp codes (000 add, 001 sub, 010 funct) from a shared package, mips_ctrl_pkg.
REQ-035 SHALL be a single module with no sub-modules: one state register, next-state logic and output decode.

Verification
REQ-036 SHALL test: reset release, then OP=100011 with mem_ready=1 -> IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemToReg=1 only in MEMWB; instr_done one cycle later.
REQ-037 SHALL test: OP=101011, mem_ready held 0 for 3 cycles in MEMWR -> MemToWrite=1 for exactly 4 cycles, then FETCH.
REQ-038 SHALL test: OP=000100 -> BEQ_EX with PCWriteCond=1, PCSource=01, ALUOp=001; total 3 cycles.
REQ-039 SHALL test: OP=111111 -> DECODE then FETCH; illegal_op pulses once; no RegWrite, MemToWrite or PCWrite beyond FETCH.
REQ-040 SHALL test: rst_n dropped during RTYPE_EX -> all outputs 0 within the same cycle; after release, IDLE then FETCH.
REQ-041 SHALL test: mem_ready=0 for 2 cycles in FETCH -> IRWrite and PCWrite stay 0 until the mem_ready=1 cycle, then pulse exactly once.
